i_decode: RTL

Instruction-decode stage: consumes nPC/IR from the IF/ID buffer and decodes the opcode into pipeline control. Reads two operands from an internal 32x32 register file and sign-extends the immediate. Registers everything into an ID/EX pipeline buffer. Accepts the write-back port from the WB stage and a flush from branch resolution.

---
 rtl/i_decode_if.sv | 39 +++
 rtl/i_decode.sv | 89 ++++++++
 2 files changed

// File: rtl/i_decode_if.sv
// Signal bundle between the IF/ID buffer, the WB stage and the ID/EX buffer.
// The master drives the stage inputs; the slave (the decode stage) drives the *_ex outputs.
interface i_decode_if #(parameter int WORD = 32);
  logic [WORD-1:0] nPC_id;
  logic [WORD-1:0] IR_id;
  logic            flush;
  logic            RegWrite_wb;
  logic [4:0]      WriteReg_wb;
  logic [WORD-1:0] WriteData_wb;

  logic [WORD-1:0] nPC_ex;
  logic [WORD-1:0] rd1_ex;
  logic [WORD-1:0] rd2_ex;
  logic [WORD-1:0] imm_ex;
  logic [4:0]      rt_ex;
  logic [4:0]      rd_ex;
  logic            RegDst_ex;
  logic            ALUSrc_ex;
  logic            MemRead_ex;
  logic            MemWrite_ex;
  logic            Branch_ex;
  logic            MemtoReg_ex;
  logic            RegWrite_ex;
  logic [1:0]      ALUOp_ex;

  modport master (
    output nPC_id, IR_id, flush, RegWrite_wb, WriteReg_wb, WriteData_wb,
    input  nPC_ex, rd1_ex, rd2_ex, imm_ex, rt_ex, rd_ex,
           RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, Branch_ex,
           MemtoReg_ex, RegWrite_ex, ALUOp_ex
  );

  modport slave (
    input  nPC_id, IR_id, flush, RegWrite_wb, WriteReg_wb, WriteData_wb,
    output nPC_ex, rd1_ex, rd2_ex, imm_ex, rt_ex, rd_ex,
           RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, Branch_ex,
           MemtoReg_ex, RegWrite_ex, ALUOp_ex
  );
endinterface

// File: rtl/i_decode.sv
// Instruction-decode stage: opcode decode, 32-entry register file with WB bypass,
// immediate sign extension and the ID/EX pipeline buffer.
module i_decode #(
  parameter int WORD  = 32,
  parameter int NREGS = 32
) (
  input logic       clk,
  input logic       reset,
  i_decode_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [WORD-1:0] regs [NREGS];
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [WORD-1:0] rd1;
  logic [WORD-1:0] rd2;
  logic [WORD-1:0] imm;
  logic            wb_en;
  // Packed as {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
  logic [8:0]      ctrl;

  assign rs    = bus.IR_id[25:21];
  assign rt    = bus.IR_id[20:16];
  assign imm   = {{(WORD-16){bus.IR_id[15]}}, bus.IR_id[15:0]};
  assign wb_en = bus.RegWrite_wb && (bus.WriteReg_wb != 5'd0);

  always_comb begin
    ctrl = 9'b0;
    case (bus.IR_id[31:26])
      OP_RTYPE: ctrl = 9'b1_0_0_1_0_0_0_10;
      OP_LW:    ctrl = 9'b0_1_1_1_1_0_0_00;
      OP_SW:    ctrl = 9'b0_1_0_0_0_1_0_00;
      OP_BEQ:   ctrl = 9'b0_0_0_0_0_0_1_01;
      OP_ADDI:  ctrl = 9'b0_1_0_1_0_0_0_00;
      default:  ctrl = 9'b0;
    endcase
  end

  // Write-first reads: a same-edge WB write to rs/rt is visible to this capture.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) rd1 = (wb_en && bus.WriteReg_wb == rs) ? bus.WriteData_wb : regs[rs];
    if (rt != 5'd0) rd2 = (wb_en && bus.WriteReg_wb == rt) ? bus.WriteData_wb : regs[rt];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.WriteReg_wb] <= bus.WriteData_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.nPC_ex      <= '0;
      bus.rd1_ex      <= '0;
      bus.rd2_ex      <= '0;
      bus.imm_ex      <= '0;
      bus.rt_ex       <= '0;
      bus.rd_ex       <= '0;
      bus.RegDst_ex   <= 1'b0;
      bus.ALUSrc_ex   <= 1'b0;
      bus.MemtoReg_ex <= 1'b0;
      bus.RegWrite_ex <= 1'b0;
      bus.MemRead_ex  <= 1'b0;
      bus.MemWrite_ex <= 1'b0;
      bus.Branch_ex   <= 1'b0;
      bus.ALUOp_ex    <= 2'b00;
    end else begin
      bus.nPC_ex <= bus.nPC_id;
      bus.rd1_ex <= rd1;
      bus.rd2_ex <= rd2;
      bus.imm_ex <= imm;
      bus.rt_ex  <= bus.IR_id[20:16];
      bus.rd_ex  <= bus.IR_id[15:11];
      // A flush only bubbles the control; the datapath fields still advance.
      {bus.RegDst_ex, bus.ALUSrc_ex, bus.MemtoReg_ex, bus.RegWrite_ex,
       bus.MemRead_ex, bus.MemWrite_ex, bus.Branch_ex, bus.ALUOp_ex}
        <= bus.flush ? 9'b0 : ctrl;
    end
  end
endmodule
